// File: rtl/aload_seq_pkg.sv
// ---------------------------------------------------------------------------
// aload_seq_pkg
//   Shared types and constants for the async-load register sequencer.
//   - state_e     : sequencer FSM states
//   - KIND_LOAD   : request kind for a clocked load through EN/D
//   - KIND_PRESET : request kind for an async preset through ALOAD/AD
// ---------------------------------------------------------------------------
package aload_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    PRESET = 2'd2,
    SETTLE = 2'd3
  } state_e;

  localparam logic KIND_LOAD   = 1'b0;
  localparam logic KIND_PRESET = 1'b1;

endpackage : aload_seq_pkg

// File: rtl/aload_seq_hold_cnt.sv
// ---------------------------------------------------------------------------
// aload_seq_hold_cnt
//   Loadable down-counter that times how long ALOAD stays asserted.
//   The counter loads HOLD_CYCLES-1 and stops at zero, so it never wraps.
// Ports
//   pos_clk  in   clock, rising edge
//   rst      in   synchronous reset, active-high
//   load     in   load HOLD_CYCLES-1 (takes priority over dec)
//   dec      in   decrement by one while non-zero
//   zero     out  counter value is zero
// ---------------------------------------------------------------------------
module aload_seq_hold_cnt #(
  parameter int HOLD_CYCLES = 2
) (
  input  logic pos_clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge pos_clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(HOLD_CYCLES - 1);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule : aload_seq_hold_cnt

// File: rtl/aload_seq_ctrl.sv
// ---------------------------------------------------------------------------
// aload_seq_ctrl
//   Sequencer placed directly in front of an async-load/enable register.
//   Each accepted request becomes either a one-cycle clocked load (EN/D) or
//   an async preset (ALOAD/AD) held for HOLD_CYCLES cycles, followed by a
//   one-cycle SETTLE state that pulses DONE.
//
// Parameters
//   WIDTH        data width of REQ_DATA, D, AD, Q_IN
//   HOLD_CYCLES  cycles ALOAD is held per preset (>= 1)
//
// Ports
//   CLK        in   clock, rising edge
//   RST        in   synchronous reset, active-high
//   REQ_VALID  in   request valid
//   REQ_READY  out  request ready, high only in IDLE
//   REQ_KIND   in   0 = clocked load, 1 = async preset
//   REQ_DATA   in   value to place in the register
//   D, EN      out  register clocked-load inputs
//   AD, ALOAD  out  register async-load inputs
//   BUSY       out  high whenever not in IDLE
//   DONE       out  one-cycle completion pulse
//   Q_IN       in   register readback (used only by the checker)
//   ERR        out  sticky readback mismatch flag
//
// Build option
//   ALOAD_SEQ_CHECK_EN : when defined, Q_IN is compared against the accepted
//                        value during SETTLE and ERR latches any mismatch.
//                        When undefined, ERR is tied low.
// ---------------------------------------------------------------------------
module aload_seq_ctrl
  import aload_seq_pkg::*;
#(
  parameter int WIDTH       = 2,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic             REQ_KIND,
  input  logic [WIDTH-1:0] REQ_DATA,
  output logic [WIDTH-1:0] D,
  output logic             EN,
  output logic [WIDTH-1:0] AD,
  output logic             ALOAD,
  output logic             BUSY,
  output logic             DONE,
  input  logic [WIDTH-1:0] Q_IN,
  output logic             ERR
);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("aload_seq_ctrl: HOLD_CYCLES must be >= 1");
  end

  state_e           state, state_next;
  logic             accept;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [WIDTH-1:0] exp_q;

  aload_seq_hold_cnt #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_hold_cnt (
    .pos_clk(CLK),
    .rst    (RST),
    .load   (cnt_load),
    .dec    (cnt_dec),
    .zero   (cnt_zero)
  );

  assign REQ_READY = (state == IDLE);
  assign BUSY      = (state != IDLE);
  assign accept    = REQ_VALID && (state == IDLE);

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_next = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (REQ_KIND == KIND_PRESET) begin
            state_next = PRESET;
            cnt_load   = 1'b1;
          end else begin
            state_next = LOAD;
          end
        end
      end
      LOAD:   state_next = SETTLE;
      PRESET: begin
        if (cnt_zero) state_next = SETTLE;
        else          cnt_dec    = 1'b1;
      end
      SETTLE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up exactly with
  // the state they belong to; D/AD change only on accept and otherwise hold.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (RST) begin
      state <= IDLE;
      EN    <= 1'b0;
      ALOAD <= 1'b0;
      DONE  <= 1'b0;
      D     <= '0;
      AD    <= '0;
      exp_q <= '0;
    end else begin
      state <= state_next;
      EN    <= (state_next == LOAD);
      ALOAD <= (state_next == PRESET);
      DONE  <= (state_next == SETTLE);
      if (accept) begin
        exp_q <= REQ_DATA;
        if (REQ_KIND == KIND_PRESET) AD <= REQ_DATA;
        else                         D  <= REQ_DATA;
      end
    end
  end

`ifdef ALOAD_SEQ_CHECK_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      ERR <= 1'b0;
    end else if ((state == SETTLE) && (Q_IN != exp_q)) begin
      ERR <= 1'b1;
    end
  end
`else
  // Readback is not checked in this build; fold the inputs into a sink.
  logic unused_readback;
  assign unused_readback = ^{Q_IN, exp_q};
  assign ERR             = 1'b0;
`endif

endmodule : aload_seq_ctrl

// File: tb/tb_aload_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aload_seq_ctrl
//   Self-checking bench for aload_seq_ctrl (WIDTH=2, HOLD_CYCLES=2) with a
//   behavioural async-load register model on the outputs.
// ---------------------------------------------------------------------------
module tb_aload_seq_ctrl;
  import aload_seq_pkg::*;

  localparam int WIDTH = 2;
  localparam int HOLD  = 2;

`ifdef ALOAD_SEQ_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             REQ_VALID = 1'b0;
  logic             REQ_KIND = 1'b0;
  logic [WIDTH-1:0] REQ_DATA = '0;
  logic             REQ_READY, EN, ALOAD, BUSY, DONE, ERR;
  logic [WIDTH-1:0] D, AD, Q_IN;

  aload_seq_ctrl #(.WIDTH(WIDTH), .HOLD_CYCLES(HOLD)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .REQ_VALID(REQ_VALID),
    .REQ_READY(REQ_READY),
    .REQ_KIND (REQ_KIND),
    .REQ_DATA (REQ_DATA),
    .D        (D),
    .EN       (EN),
    .AD       (AD),
    .ALOAD    (ALOAD),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .Q_IN     (Q_IN),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  // Downstream register model: ALOAD is transparent while high, EN loads on
  // the clock. force_bad makes a clocked load capture 00 instead of D.
  logic [WIDTH-1:0] q_reg = 2'b11;
  bit               force_bad = 1'b0;
  always @(posedge CLK) begin
    if (ALOAD)   q_reg <= AD;
    else if (EN) q_reg <= force_bad ? 2'b00 : D;
  end
  assign Q_IN = ALOAD ? AD : q_reg;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [WIDTH-1:0] data;
    int               done_cyc;
    bit               chk_q;
  } sb_t;
  sb_t sb[$];
  sb_t sb_e;

  int done_count = 0;
  bit overlap_seen = 1'b0;
  bit ready_busy_bad = 1'b0;

  // Output monitor: pops the scoreboard on every DONE pulse.
  always @(negedge CLK) begin
    if (EN && ALOAD) overlap_seen = 1'b1;
    if (REQ_READY == BUSY) ready_busy_bad = 1'b1;
    if (DONE) begin
      done_count++;
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        sb_e = sb.pop_front();
        check("done_cycle", cyc, sb_e.done_cyc);
        if (sb_e.chk_q) check("q_after_done", Q_IN, sb_e.data);
      end
    end
  end

  logic [WIDTH-1:0] last_d = '0;
  logic [WIDTH-1:0] last_ad = '0;

  // Waits for REQ_READY and returns #1 after the accept edge.
  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (REQ_READY) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      @(posedge CLK);
      #1;
    end else begin
      check("accept_timeout", 0, 1);
    end
  endtask

  task automatic run_vec(input logic kind, input logic [WIDTH-1:0] data, input int lat);
    bit ok;
    REQ_VALID = 1'b1;
    REQ_KIND  = kind;
    REQ_DATA  = data;
    wait_accept(ok);
    REQ_VALID = 1'b0;
    if (!ok) return;
    sb.push_back('{data, cyc + lat, !force_bad});
    if (kind == KIND_LOAD) begin
      @(negedge CLK);
      check("load_en", EN, 1);
      check("load_d", D, data);
      check("load_aload", ALOAD, 0);
      check("load_ad_hold", AD, last_ad);
      check("load_ready_low", REQ_READY, 0);
      @(negedge CLK);
      check("settle_en", EN, 0);
      last_d = data;
    end else begin
      for (int h = 0; h < HOLD; h++) begin
        @(negedge CLK);
        check("preset_aload", ALOAD, 1);
        check("preset_ad", AD, data);
        check("preset_en", EN, 0);
        check("preset_d_hold", D, last_d);
      end
      @(negedge CLK);
      check("settle_aload", ALOAD, 0);
      last_ad = data;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      #2;
      if (sb.size() == 0 && !BUSY) break;
    end
    check("drain", sb.size(), 0);
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic             kind;
    logic [WIDTH-1:0] data;
    int               lat;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int prev_acc, prev_lat, d0;

    vecs[0] = '{KIND_LOAD,   2'b10, 1};
    vecs[1] = '{KIND_PRESET, 2'b01, HOLD};
    vecs[2] = '{KIND_LOAD,   2'b11, 1};
    vecs[3] = '{KIND_PRESET, 2'b10, HOLD};
    vecs[4] = '{KIND_PRESET, 2'b00, HOLD};
    vecs[5] = '{KIND_LOAD,   2'b01, 1};

    // Reset state
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_d", D, 0);
    check("rst_ad", AD, 0);
    check("rst_en", EN, 0);
    check("rst_aload", ALOAD, 0);
    check("rst_done", DONE, 0);
    check("rst_err", ERR, 0);
    check("rst_ready", REQ_READY, 1);
    check("rst_busy", BUSY, 0);
    check("rst_q_unchanged", Q_IN, 2'b11);
    @(posedge CLK);
    #1;

    // Table-driven single requests
    foreach (vecs[i]) run_vec(vecs[i].kind, vecs[i].data, vecs[i].lat);
    drain();

    // REQ_VALID held high with alternating kinds
    REQ_VALID = 1'b1;
    prev_acc  = 0;
    prev_lat  = 0;
    for (int i = 0; i < 4; i++) begin
      REQ_KIND = i[0];
      REQ_DATA = WIDTH'(i + 1);
      wait_accept(ok);
      if (!ok) break;
      sb.push_back('{REQ_DATA, cyc + (i[0] ? HOLD : 1), 1'b1});
      if (i[0]) last_ad = REQ_DATA;
      else      last_d  = REQ_DATA;
      if (i > 0) check("b2b_accept_gap", cyc - prev_acc, prev_lat + 2);
      prev_acc = cyc;
      prev_lat = i[0] ? HOLD : 1;
      @(negedge CLK);
      check("b2b_ready_low", REQ_READY, 0);
    end
    REQ_VALID = 1'b0;
    drain();

    // Reset during the first PRESET cycle
    REQ_VALID = 1'b1;
    REQ_KIND  = KIND_PRESET;
    REQ_DATA  = 2'b11;
    wait_accept(ok);
    REQ_VALID = 1'b0;
    RST       = 1'b1;
    d0        = done_count;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_mid_aload", ALOAD, 0);
    check("rst_mid_en", EN, 0);
    check("rst_mid_ready", REQ_READY, 1);
    check("rst_mid_busy", BUSY, 0);
    repeat (4) @(negedge CLK);
    check("rst_mid_no_done", done_count - d0, 0);
    last_d  = '0;
    last_ad = '0;
    @(posedge CLK);
    #1;

    // Readback mismatch: register model drops a load of 11
    force_bad = 1'b1;
    run_vec(KIND_LOAD, 2'b11, 1);
    force_bad = 1'b0;
    @(negedge CLK);
    check("err_after_bad", ERR, CHK_EN);
    @(posedge CLK);
    #1;
    run_vec(KIND_LOAD, 2'b10, 1);
    run_vec(KIND_PRESET, 2'b01, HOLD);
    @(negedge CLK);
    check("err_sticky", ERR, CHK_EN);
    @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("err_cleared", ERR, 0);

    check("no_en_aload_overlap", overlap_seen, 0);
    check("ready_is_not_busy", ready_busy_bad, 0);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_aload_seq_ctrl
